// File: rtl/cam_dvp_capture.sv
// DVP camera frame capture: oversampled pclk/sync inputs, byte packing,
// pixel FIFO with valid/ready output and frame bookkeeping.
module cam_dvp_capture #(
  parameter int DATA_W     = 8,
  parameter int BPP        = 2,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int XCLK_DIV   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic                    continuous_i,
  input  logic                    abort_i,
  output logic                    xclk_o,
  input  logic                    pclk_i,
  input  logic                    vsync_i,
  input  logic                    hsync_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [DATA_W*BPP-1:0]   pix_data_o,
  output logic                    pix_valid_o,
  input  logic                    pix_ready_i,
  output logic                    pix_sof_o,
  output logic                    pix_eol_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    overflow_o,
  output logic                    size_err_o,
  output logic [CNT_W-1:0]        frame_cnt_o
);

  localparam int PIX_W = DATA_W * BPP;
  localparam int BC_W  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int X_W   = $clog2(IMG_W + 1);
  localparam int Y_W   = $clog2(IMG_H + 2);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int XD_W  = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPP - 1);
  localparam logic [X_W-1:0]  X_MAX   = X_W'(IMG_W);
  localparam logic [X_W-1:0]  X_LAST  = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]  Y_EXP   = Y_W'(IMG_H);
  localparam logic [Y_W-1:0]  Y_SAT   = Y_W'(IMG_H + 1);
  localparam logic [XD_W-1:0] XD_LAST = XD_W'(XCLK_DIV - 1);
  localparam logic [AW:0]     F_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, SYNC, WAIT_FRAME, CAPTURE
  } state_t;

  state_t state;

  logic [XD_W-1:0] xdiv_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      xdiv_q <= '0;
      xclk_o <= 1'b0;
    end else if (xdiv_q == XD_LAST) begin
      xdiv_q <= '0;
      xclk_o <= ~xclk_o;
    end else begin
      xdiv_q <= xdiv_q + 1'b1;
    end
  end

  logic [1:0]        pclk_s, vs_s, hs_s;
  logic [DATA_W-1:0] d_s0, d_s1;
  logic              pclk_d, vs_d, hs_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pclk_s <= '0;
      vs_s   <= '0;
      hs_s   <= '0;
      d_s0   <= '0;
      d_s1   <= '0;
      pclk_d <= 1'b0;
      vs_d   <= 1'b0;
      hs_d   <= 1'b0;
    end else begin
      pclk_s <= {pclk_s[0], pclk_i};
      vs_s   <= {vs_s[0], vsync_i};
      hs_s   <= {hs_s[0], hsync_i};
      d_s0   <= data_i;
      d_s1   <= d_s0;
      pclk_d <= pclk_s[1];
      vs_d   <= vs_s[1];
      hs_d   <= hs_s[1];
    end
  end

  logic pclk_rise, vs_rise, vs_fall, hs_fall, take;

  assign pclk_rise = pclk_s[1] & ~pclk_d;
  assign vs_rise   = vs_s[1] & ~vs_d;
  assign vs_fall   = ~vs_s[1] & vs_d;
  assign hs_fall   = ~hs_s[1] & hs_d;
  assign take      = (state == CAPTURE) && pclk_rise && hs_s[1];

  logic [BC_W-1:0]  byte_cnt;
  logic [X_W-1:0]   x_cnt;
  logic [Y_W-1:0]   y_cnt;
  logic [PIX_W-1:0] pix_sh, pix_next;
  logic             cont_q;
  logic             push_q, push_sof_q, push_eol_q;
  logic [PIX_W-1:0] push_data_q;

  // first byte of a pixel lands in the most significant slot
  always_comb begin
    pix_next = pix_sh;
    pix_next[(BPP - 1 - int'(byte_cnt)) * DATA_W +: DATA_W] = d_s1;
  end

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               full, pop, wr_en, ovf_evt;
  logic [PIX_W+1:0]   mem [FIFO_DEPTH];
  logic [PIX_W+1:0]   head;

  assign full        = (count == F_FULL);
  assign pix_valid_o = (count != '0);
  assign pop         = pix_valid_o && pix_ready_i;
  assign wr_en       = push_q && (!full || pop);
  assign ovf_evt     = push_q && full && !pop;
  assign head        = mem[rd_ptr];
  assign pix_data_o  = pix_valid_o ? head[PIX_W-1:0] : '0;
  assign pix_sof_o   = pix_valid_o & head[PIX_W+1];
  assign pix_eol_o   = pix_valid_o & head[PIX_W];
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      pix_sh       <= '0;
      cont_q       <= 1'b0;
      push_q       <= 1'b0;
      push_sof_q   <= 1'b0;
      push_eol_q   <= 1'b0;
      push_data_q  <= '0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      overflow_o   <= 1'b0;
      size_err_o   <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      push_q       <= 1'b0;
      if (ovf_evt) overflow_o <= 1'b1;
      if (abort_i) begin
        state    <= IDLE;
        byte_cnt <= '0;
        x_cnt    <= '0;
        y_cnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_i) begin
              state      <= SYNC;
              cont_q     <= continuous_i;
              overflow_o <= 1'b0;
              size_err_o <= 1'b0;
              byte_cnt   <= '0;
              x_cnt      <= '0;
              y_cnt      <= '0;
            end
          end
          SYNC: begin
            if (vs_s[1]) state <= WAIT_FRAME;
          end
          WAIT_FRAME: begin
            if (vs_fall) begin
              state    <= CAPTURE;
              byte_cnt <= '0;
              x_cnt    <= '0;
              y_cnt    <= '0;
            end
          end
          CAPTURE: begin
            if (vs_rise) begin
              frame_done_o <= 1'b1;
              frame_cnt_o  <= frame_cnt_o + 1'b1;
              if (y_cnt != Y_EXP) size_err_o <= 1'b1;
              state <= cont_q ? WAIT_FRAME : IDLE;
            end else if (hs_fall) begin
              if (y_cnt != Y_SAT) y_cnt <= y_cnt + 1'b1;
              x_cnt    <= '0;
              byte_cnt <= '0;
              if (x_cnt != X_MAX || byte_cnt != '0)
                size_err_o <= 1'b1;
            end else if (take) begin
              if (x_cnt == X_MAX) begin
                size_err_o <= 1'b1;
              end else begin
                pix_sh <= pix_next;
                if (byte_cnt == BC_LAST) begin
                  byte_cnt    <= '0;
                  x_cnt       <= x_cnt + 1'b1;
                  push_q      <= 1'b1;
                  push_data_q <= pix_next;
                  push_sof_q  <= (x_cnt == '0) && (y_cnt == '0);
                  push_eol_q  <= (x_cnt == X_LAST);
                end else begin
                  byte_cnt <= byte_cnt + 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // a pop on a full FIFO frees the slot the same-cycle push writes into
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en}
                     - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= {push_sof_q, push_eol_q, push_data_q};
  end

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture: 4x2 frames, 2 bytes/pixel,
// 4-entry FIFO, xclk divide by 2.
module tb_cam_dvp_capture;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        xclk_o;
  logic        pclk_i = 1'b0;
  logic        vsync_i = 1'b0;
  logic        hsync_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic [15:0] pix_data_o;
  logic        pix_valid_o;
  logic        pix_ready_i = 1'b0;
  logic        pix_sof_o;
  logic        pix_eol_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        overflow_o;
  logic        size_err_o;
  logic [15:0] frame_cnt_o;

  cam_dvp_capture #(
    .DATA_W(8), .BPP(2), .IMG_W(4), .IMG_H(2),
    .FIFO_DEPTH(4), .XCLK_DIV(2), .CNT_W(16)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .start_i(start_i), .continuous_i(continuous_i),
    .abort_i(abort_i), .xclk_o(xclk_o),
    .pclk_i(pclk_i), .vsync_i(vsync_i),
    .hsync_i(hsync_i), .data_i(data_i),
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i), .pix_sof_o(pix_sof_o),
    .pix_eol_o(pix_eol_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .overflow_o(overflow_o),
    .size_err_o(size_err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt = 0;
  logic [17:0] q[$];

  always @(negedge clk_i) begin
    if (rst_n_i && pix_valid_o && pix_ready_i)
      q.push_back({pix_sof_o, pix_eol_o, pix_data_o});
    if (frame_done_o) fd_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cam_byte(input logic [7:0] d);
    hsync_i = 1'b1;
    data_i  = d;
    #40 pclk_i = 1'b1;
    #40 pclk_i = 1'b0;
  endtask

  task automatic cam_line(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) cam_byte(base + 8'(i));
    hsync_i = 1'b0;
    #200;
  endtask

  task automatic frame_begin();
    vsync_i = 1'b1;
    #200 vsync_i = 1'b0;
    #200;
  endtask

  task automatic frame_end();
    hsync_i = 1'b0;
    vsync_i = 1'b1;
    #400;
  endtask

  task automatic do_start(input logic cont);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    continuous_i = cont;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i) rst_n_i = 1'b0;
    @(negedge clk_i) rst_n_i = 1'b1;
  endtask

  logic [17:0] exp1 [8];
  logic [17:0] exp4 [7];
  logic [7:0]  xpat;
  int fd0;

  initial begin
    exp1 = '{{2'b10, 16'h0001}, {2'b00, 16'h0203},
             {2'b00, 16'h0405}, {2'b01, 16'h0607},
             {2'b00, 16'h0809}, {2'b00, 16'h0A0B},
             {2'b00, 16'h0C0D}, {2'b01, 16'h0E0F}};
    exp4 = '{{2'b10, 16'h0001}, {2'b00, 16'h0203},
             {2'b00, 16'h0405}, {2'b00, 16'h1011},
             {2'b00, 16'h1213}, {2'b00, 16'h1415},
             {2'b01, 16'h1617}};
    xpat = 8'b0110_0110;

    #23;
    check("rst_valid", pix_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", frame_cnt_o, 0);
    check("rst_flags", {overflow_o, size_err_o, frame_done_o}, 0);
    check("rst_xclk", xclk_o, 0);
    @(negedge clk_i) rst_n_i = 1'b1;
    repeat (4) @(posedge clk_i);

    // single-shot frame, consumer always ready
    pix_ready_i = 1'b1;
    q.delete();
    fd0 = fd_cnt;
    do_start(1'b0);
    check("t1_busy", busy_o, 1);
    frame_begin();
    cam_line(8'h00, 8);
    cam_line(8'h08, 8);
    frame_end();
    repeat (20) @(negedge clk_i);
    check("t1_npix", q.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_pix%0d", i), q[i], exp1[i]);
    check("t1_done", fd_cnt - fd0, 1);
    check("t1_cnt", frame_cnt_o, 1);
    check("t1_busy_end", busy_o, 0);
    check("t1_flags", {overflow_o, size_err_o}, 0);

    // continuous, three frames, abort inside frame four
    do_reset();
    q.delete();
    fd0 = fd_cnt;
    do_start(1'b1);
    for (int f = 0; f < 3; f++) begin
      frame_begin();
      cam_line(8'h00, 8);
      cam_line(8'h08, 8);
      frame_end();
    end
    vsync_i = 1'b0;
    #200;
    cam_byte(8'h00);
    cam_byte(8'h01);
    cam_byte(8'h02);
    #100;
    @(posedge clk_i); #1 abort_i = 1'b1;
    @(posedge clk_i); #1 abort_i = 1'b0;
    check("t2_busy", busy_o, 0);
    check("t2_valid", pix_valid_o, 0);
    hsync_i = 1'b0;
    vsync_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("t2_cnt", frame_cnt_o, 3);
    check("t2_done", fd_cnt - fd0, 3);
    check("t2_npix", q.size(), 25);
    check("t2_last", q[24], {2'b10, 16'h0001});
    check("t2_valid_end", pix_valid_o, 0);

    // overflow with stalled consumer
    do_reset();
    pix_ready_i = 1'b0;
    q.delete();
    do_start(1'b0);
    frame_begin();
    cam_line(8'h00, 8);
    cam_line(8'h08, 4);
    frame_end();
    repeat (10) @(negedge clk_i);
    check("t3_ovf", overflow_o, 1);
    check("t3_valid", pix_valid_o, 1);
    check("t3_head", pix_data_o, 16'h0001);
    check("t3_held", q.size(), 0);
    pix_ready_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("t3_npix", q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_pix%0d", i), q[i][15:0], exp1[i][15:0]);

    // short line with odd byte count
    q.delete();
    do_start(1'b0);
    check("t4_ovf_clr", overflow_o, 0);
    check("t4_err_clr", size_err_o, 0);
    frame_begin();
    cam_line(8'h00, 7);
    cam_line(8'h10, 8);
    frame_end();
    repeat (20) @(negedge clk_i);
    check("t4_err", size_err_o, 1);
    check("t4_npix", q.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t4_pix%0d", i), q[i], exp4[i]);

    // frame with a single line
    fd0 = fd_cnt;
    do_start(1'b0);
    check("t5_err_clr", size_err_o, 0);
    frame_begin();
    cam_line(8'h00, 8);
    frame_end();
    repeat (20) @(negedge clk_i);
    check("t5_done", fd_cnt - fd0, 1);
    check("t5_err", size_err_o, 1);
    check("t5_cnt", frame_cnt_o, 3);

    // asynchronous reset mid-frame, then xclk phase from release
    pix_ready_i = 1'b0;
    do_start(1'b0);
    frame_begin();
    for (int i = 0; i < 4; i++) cam_byte(8'(i));
    #100;
    check("t6_valid_pre", pix_valid_o, 1);
    check("t6_busy_pre", busy_o, 1);
    @(posedge clk_i); #3 rst_n_i = 1'b0;
    #1;
    check("t6_valid", pix_valid_o, 0);
    check("t6_data", pix_data_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_cnt", frame_cnt_o, 0);
    check("t6_flags", {overflow_o, size_err_o, frame_done_o}, 0);
    check("t6_xclk", xclk_o, 0);
    hsync_i = 1'b0;
    @(negedge clk_i) rst_n_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check($sformatf("xclk%0d", i), xclk_o, xpat[7-i]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
